// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed program image over an 8N1 serial
// line, writes it word by word into instruction memory and releases the core once it has verified.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              UART_RX,
  output logic              Core_RST,
  output logic              IMEM_W_En,
  output logic [ADDR_W-1:0] IMEM_W_Addr,
  output logic [31:0]       IMEM_W_Data,
  output logic              Load_Done,
  output logic              Load_Err
);

  localparam int unsigned      CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(2 ** ADDR_W);
  localparam logic [7:0]       HEADER    = 8'hA5;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;

  rx_state_t        rx_state, rx_next;
  logic             rx_meta, rx_sync, rx_prev;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_shift;
  logic             byte_valid, frame_err;

  state_t           state, state_next;
  logic [7:0]       len_lo;
  logic [15:0]      len_word;
  logic [15:0]      word_total;
  logic [16:0]      word_cnt;
  logic [1:0]       byte_k;
  logic [7:0]       run_xor;
  logic [23:0]      word_sr;
  logic             last_word;

  // RX front end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_sync) rx_next = RX_START;
      RX_START: if (clk_cnt == HALF_LAST) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (clk_cnt == BIT_LAST && bit_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (clk_cnt == BIT_LAST) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // The counter restarts at every state change, so after the start-bit midpoint each
  // BIT_LAST terminal count lands in the middle of the next bit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_state   <= RX_IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      rx_shift   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_state   <= rx_next;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (rx_state == RX_IDLE || rx_next != rx_state || clk_cnt == BIT_LAST)
        clk_cnt <= '0;
      else
        clk_cnt <= clk_cnt + 1'b1;
      if (rx_state == RX_START)
        bit_idx <= '0;
      if (rx_state == RX_DATA && clk_cnt == BIT_LAST) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};
        bit_idx  <= bit_idx + 1'b1;
      end
      if (rx_state == RX_STOP && clk_cnt == BIT_LAST) begin
        byte_valid <= 1'b1;
        frame_err  <= !rx_sync;
      end
    end
  end

  // Loader FSM

  assign len_word  = {rx_shift, len_lo};
  assign last_word = (word_cnt + 17'd1) == {1'b0, word_total};

  always_comb begin
    state_next = state;
    if (frame_err && (state inside {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM})) begin
      state_next = S_ERR;
    end else if (byte_valid && !frame_err) begin
      case (state)
        S_IDLE, S_ERR: if (rx_shift == HEADER) state_next = S_LEN_LO;
        S_LEN_LO:      state_next = S_LEN_HI;
        S_LEN_HI: begin
          if ({1'b0, len_word} > MAX_WORDS) state_next = S_ERR;
          else if (len_word == '0)          state_next = S_CSUM;
          else                              state_next = S_DATA;
        end
        S_DATA:        if (byte_k == 2'd3 && last_word) state_next = S_CSUM;
        S_CSUM:        state_next = (rx_shift == run_xor) ? S_DONE : S_ERR;
        default:       state_next = state;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= S_IDLE;
      len_lo      <= '0;
      word_total  <= '0;
      word_cnt    <= '0;
      byte_k      <= '0;
      run_xor     <= '0;
      word_sr     <= '0;
      IMEM_W_En   <= 1'b0;
      IMEM_W_Addr <= '0;
      IMEM_W_Data <= '0;
      Core_RST    <= 1'b1;
      Load_Done   <= 1'b0;
      Load_Err    <= 1'b0;
    end else begin
      state     <= state_next;
      IMEM_W_En <= 1'b0;
      if (IMEM_W_En)
        IMEM_W_Addr <= IMEM_W_Addr + 1'b1;
      if (byte_valid && !frame_err) begin
        case (state)
          S_LEN_LO: len_lo <= rx_shift;
          S_LEN_HI: begin
            word_total  <= len_word;
            word_cnt    <= '0;
            byte_k      <= '0;
            run_xor     <= '0;
            IMEM_W_Addr <= '0;
          end
          S_DATA: begin
            word_sr <= {rx_shift, word_sr[23:8]};
            run_xor <= run_xor ^ rx_shift;
            byte_k  <= byte_k + 1'b1;
            if (byte_k == 2'd3) begin
              IMEM_W_En   <= 1'b1;
              IMEM_W_Data <= {rx_shift, word_sr};
              word_cnt    <= word_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end
      Core_RST  <= (state_next != S_DONE);
      Load_Done <= (state_next == S_DONE);
      Load_Err  <= (state_next == S_ERR);
    end
  end

endmodule
